// File: rtl/tl_pkg.sv
// Shared definitions for the N-approach traffic light controller.
//   tl_state_e   : controller state (GREEN, ALL_RED, FLASH, POLICE)
//   lamp_onehot  : approach index -> one-hot lamp vector (8 lanes max)
//   bin_to_bcd8  : binary seconds (0..99) -> two BCD digits; only ever
//                  applied to elaboration-time constants (green times)
package tl_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        ALL_RED = 2'd1,
        FLASH   = 2'd2,
        POLICE  = 2'd3
    } tl_state_e;

    localparam int MAX_APP = 8;

    function automatic logic [7:0] lamp_onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    function automatic logic [7:0] bin_to_bcd8(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_n_if.sv
// Signal bundle between the intersection controller and its environment.
//   Tick       : one-cycle strobe per second
//   Sensor     : vehicle presence per approach
//   Police_req : police force-green request per approach
//   Police_rel : police release
//   Green      : one-hot green lamps (all zero = all red)
//   Flash      : flasher lamp
//   Phase      : current/next approach index
//   Bcd_tens   : remaining green seconds, tens digit
//   Bcd_units  : remaining green seconds, units digit
// master drives the inputs of the controller, slave is the controller.
interface traffic_light_ctrl_n_if #(
    parameter int N_APP = 2
) ();

    logic             Tick;
    logic [N_APP-1:0] Sensor;
    logic [N_APP-1:0] Police_req;
    logic             Police_rel;
    logic [N_APP-1:0] Green;
    logic             Flash;
    logic [2:0]       Phase;
    logic [3:0]       Bcd_tens;
    logic [3:0]       Bcd_units;

    modport master (
        output Tick, Sensor, Police_req, Police_rel,
        input  Green, Flash, Phase, Bcd_tens, Bcd_units
    );

    modport slave (
        input  Tick, Sensor, Police_req, Police_rel,
        output Green, Flash, Phase, Bcd_tens, Bcd_units
    );

endinterface

// File: rtl/bcd_down_cnt2.sv
// Two-digit BCD down-counter used as the green-time display/timer.
// Ports:
//   Clk, Rst  : clock, synchronous active-high reset (clears to 00)
//   load      : load load_val (two BCD digits), has priority over dec
//   load_val  : {tens, units} value to load
//   dec       : count down by one; holds at 00
//   tens      : tens digit
//   units     : units digit
//   zero      : high when the counter shows 00
module bcd_down_cnt2 (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       zero
);

    assign zero = (tens == 4'd0) && (units == 4'd0);

    // Native BCD decrement: a units borrow takes one from tens and
    // reloads units with 9, so no binary-to-BCD conversion is needed.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tens  <= 4'd0;
            units <= 4'd0;
        end else if (load) begin
            tens  <= load_val[7:4];
            units <= load_val[3:0];
        end else if (dec && !zero) begin
            if (units == 4'd0) begin
                tens  <= tens - 4'd1;
                units <= 4'd9;
            end else begin
                units <= units - 4'd1;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-approach intersection controller.
// Cycles approaches 0..N_APP-1 through GREEN -> ALL_RED, shows remaining
// green seconds as two BCD digits, falls into a flasher mode after a long
// idle spell and wakes on sustained sensor activity, and supports a police
// override that forces a single approach green.
// Ports:
//   Clk  : system clock, rising edge
//   Rst  : synchronous active-high reset
//   bus  : slave side of traffic_light_ctrl_n_if (Tick, Sensor, Police_req,
//          Police_rel in; Green, Flash, Phase, Bcd_tens, Bcd_units out)
module traffic_light_ctrl_n
    import tl_pkg::*;
#(
    parameter int               N_APP    = 2,
    parameter logic [N_APP*7-1:0] GREEN_T = {7'd30, 7'd90},
    parameter int               ALLRED_T = 5,
    parameter int               IDLE_T   = 125,
    parameter int               WAKE_T   = 5
) (
    input logic Clk,
    input logic Rst,
    traffic_light_ctrl_n_if.slave bus
);

    localparam logic [3:0] ALLRED_LOAD = 4'(ALLRED_T);
    localparam logic [7:0] IDLE_LAST   = 8'(IDLE_T - 1);
    localparam logic [3:0] WAKE_LAST   = 4'(WAKE_T - 1);

    tl_state_e        state_q;
    logic [2:0]       phase_q;
    logic [3:0]       allred_q;
    logic [7:0]       idle_q;
    logic [3:0]       wake_q;
    logic [N_APP-1:0] green_q;
    logic             flash_q;

    logic [3:0] bcd_tens;
    logic [3:0] bcd_units;
    logic       bcd_zero;
    logic       timer_one;

    logic       any_sensor;
    logic       any_req;
    logic [2:0] police_idx;
    logic [2:0] phase_inc;
    logic [7:0] idle_inc;

    logic go_police, go_release, go_flash, go_wake, go_allred, go_green, green_dec;
    logic       cnt_load;
    logic [7:0] cnt_val;

    // Green times converted to BCD once at elaboration; unused lanes read 00.
    logic [7:0] green_bcd [MAX_APP];
    for (genvar gi = 0; gi < MAX_APP; gi++) begin : g_bcd
        if (gi < N_APP) begin : g_used
            assign green_bcd[gi] = bin_to_bcd8(GREEN_T[7*gi +: 7]);
        end else begin : g_unused
            assign green_bcd[gi] = 8'h00;
        end
    end

    assign any_sensor = |bus.Sensor;
    assign any_req    = |bus.Police_req;
    assign timer_one  = (bcd_tens == 4'd0) && (bcd_units == 4'd1);
    assign phase_inc  = (phase_q == 3'(N_APP - 1)) ? 3'd0 : phase_q + 3'd1;
    assign idle_inc   = any_sensor ? 8'd0 : idle_q + 8'd1;

    // Lowest-numbered requesting approach wins the police override.
    always_comb begin
        police_idx = 3'd0;
        for (int i = N_APP - 1; i >= 0; i--) begin
            if (bus.Police_req[i]) police_idx = 3'(i);
        end
    end

    // Transition decisions in priority order: police request, police
    // release, idle/wake, then the second timers. Police events act on any
    // cycle; everything else waits for Tick.
    always_comb begin
        go_police  = 1'b0;
        go_release = 1'b0;
        go_flash   = 1'b0;
        go_wake    = 1'b0;
        go_allred  = 1'b0;
        go_green   = 1'b0;
        green_dec  = 1'b0;
        if (state_q != POLICE && any_req) begin
            go_police = 1'b1;
        end else if (state_q == POLICE) begin
            go_release = !any_req && bus.Police_rel;
        end else if (bus.Tick) begin
            case (state_q)
                GREEN, ALL_RED: begin
                    if (!any_sensor && idle_q == IDLE_LAST) begin
                        go_flash = 1'b1;
                    end else if (state_q == GREEN) begin
                        if (timer_one || bcd_zero) go_allred = 1'b1;
                        else                       green_dec = 1'b1;
                    end else if (allred_q == 4'd1) begin
                        go_green = 1'b1;
                    end
                end
                FLASH:   go_wake = any_sensor && (wake_q == WAKE_LAST);
                default: ;
            endcase
        end
    end

    // The display counter is cleared on every state change except entry to
    // GREEN, where it takes the new approach's green time.
    assign cnt_load = go_police | go_release | go_flash | go_wake | go_allred | go_green;
    assign cnt_val  = go_green ? green_bcd[phase_q] : 8'h00;

    bcd_down_cnt2 u_display (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (green_dec),
        .tens     (bcd_tens),
        .units    (bcd_units),
        .zero     (bcd_zero)
    );

    // Main state machine; lamp outputs are registered alongside the state
    // so they change on the same edge as the state itself.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ALL_RED;
            phase_q  <= 3'd0;
            allred_q <= ALLRED_LOAD;
            idle_q   <= 8'd0;
            wake_q   <= 4'd0;
            green_q  <= '0;
            flash_q  <= 1'b0;
        end else if (go_police) begin
            state_q <= POLICE;
            phase_q <= police_idx;
            green_q <= N_APP'(lamp_onehot(police_idx));
            flash_q <= 1'b0;
            idle_q  <= 8'd0;
            wake_q  <= 4'd0;
        end else if (go_release) begin
            state_q  <= ALL_RED;
            phase_q  <= phase_inc;
            green_q  <= '0;
            allred_q <= ALLRED_LOAD;
        end else if (go_flash) begin
            state_q <= FLASH;
            green_q <= '0;
            flash_q <= 1'b0;
            idle_q  <= 8'd0;
            wake_q  <= 4'd0;
        end else if (go_wake) begin
            state_q  <= ALL_RED;
            phase_q  <= 3'd0;
            allred_q <= ALLRED_LOAD;
            flash_q  <= 1'b0;
            idle_q   <= 8'd0;
            wake_q   <= 4'd0;
        end else if (go_allred) begin
            state_q  <= ALL_RED;
            phase_q  <= phase_inc;
            green_q  <= '0;
            allred_q <= ALLRED_LOAD;
            idle_q   <= idle_inc;
        end else if (go_green) begin
            state_q <= GREEN;
            green_q <= N_APP'(lamp_onehot(phase_q));
            idle_q  <= idle_inc;
        end else if (bus.Tick) begin
            case (state_q)
                GREEN:   idle_q <= idle_inc;
                ALL_RED: begin
                    idle_q   <= idle_inc;
                    allred_q <= allred_q - 4'd1;
                end
                FLASH: begin
                    flash_q <= ~flash_q;
                    wake_q  <= any_sensor ? wake_q + 4'd1 : 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.Green     = green_q;
    assign bus.Flash     = flash_q;
    assign bus.Phase     = phase_q;
    assign bus.Bcd_tens  = bcd_tens;
    assign bus.Bcd_units = bcd_units;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed testbench for traffic_light_ctrl_n.
// Instance A: N_APP=2 with default times. Instance B: N_APP=4 with green
// times 40/30/20/10 seconds for approaches 0..3. Both share Clk and Rst.
module tb_traffic_light_ctrl_n;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    traffic_light_ctrl_n_if #(.N_APP(2)) busA ();
    traffic_light_ctrl_n_if #(.N_APP(4)) busB ();

    traffic_light_ctrl_n #(.N_APP(2)) dutA (
        .Clk (Clk),
        .Rst (Rst),
        .bus (busA)
    );

    traffic_light_ctrl_n #(
        .N_APP   (4),
        .GREEN_T ({7'd10, 7'd20, 7'd30, 7'd40})
    ) dutB (
        .Clk (Clk),
        .Rst (Rst),
        .bus (busB)
    );

    // Compare one observed value with its expected value and log misses.
    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Run n clock cycles with Tick held at the given level on both DUTs.
    task automatic applyStimulus(input int n, input bit tick);
        for (int c = 0; c < n; c++) begin
            busA.Tick = tick;
            busB.Tick = tick;
            @(posedge Clk);
            #1;
        end
        busA.Tick = 1'b0;
        busB.Tick = 1'b0;
    endtask

    task automatic pulseReset();
        Rst = 1'b1;
        applyStimulus(1, 1'b0);
        Rst = 1'b0;
    endtask

    function automatic logic [7:0] expBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // {green lamps, tens, units}
    function automatic logic [15:0] lamp(input bit useB);
        if (useB) return {8'(busB.Green), busB.Bcd_tens, busB.Bcd_units};
        return {8'(busA.Green), busA.Bcd_tens, busA.Bcd_units};
    endfunction

    function automatic logic [15:0] phaseOf(input bit useB);
        return useB ? 16'(busB.Phase) : 16'(busA.Phase);
    endfunction

    // n all-red ticks; the last one must bring up the given green.
    task automatic runAllRed(input bit useB, input int n, input logic [7:0] expGreen,
                             input int expSecs, input int expPhase, input string tag);
        for (int k = 1; k < n; k++) begin
            applyStimulus(1, 1'b1);
            checkOutput({tag, "_allred"}, lamp(useB), 16'h0000);
        end
        applyStimulus(1, 1'b1);
        checkOutput({tag, "_green_on"}, lamp(useB), {expGreen, expBcd(expSecs)});
        checkOutput({tag, "_phase"}, phaseOf(useB), 16'(expPhase));
    endtask

    // Just entered green with `secs` on the display: count down to 01, then off.
    task automatic runGreen(input bit useB, input logic [7:0] expGreen, input int secs,
                            input string tag);
        for (int k = 1; k < secs; k++) begin
            applyStimulus(1, 1'b1);
            checkOutput({tag, "_count"}, lamp(useB), {expGreen, expBcd(secs - k)});
        end
        applyStimulus(1, 1'b1);
        checkOutput({tag, "_green_off"}, lamp(useB), 16'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expFlash;
        busA.Tick = 1'b0; busA.Sensor = 2'b11;   busA.Police_req = 2'b00;   busA.Police_rel = 1'b0;
        busB.Tick = 1'b0; busB.Sensor = 4'b1111; busB.Police_req = 4'b0000; busB.Police_rel = 1'b0;
        applyStimulus(2, 1'b0);
        Rst = 1'b0;

        // T1: reset values, then a full two-approach cycle and wrap
        checkOutput("t1_reset_lamp",  lamp(0), 16'h0000);
        checkOutput("t1_reset_phase", phaseOf(0), 16'd0);
        checkOutput("t1_reset_flash", 16'(busA.Flash), 16'd0);
        runAllRed(0, 5, 8'b01, 90, 0, "t1_a0");
        runGreen(0, 8'b01, 90, "t1_g0");
        checkOutput("t1_phase_after_g0", phaseOf(0), 16'd1);
        runAllRed(0, 5, 8'b10, 30, 1, "t1_a1");
        runGreen(0, 8'b10, 30, "t1_g1");
        checkOutput("t1_phase_wrap", phaseOf(0), 16'd0);
        runAllRed(0, 5, 8'b01, 90, 0, "t1_a2");

        // T2: 125 idle ticks enter FLASH from green of approach 1, then wake
        pulseReset();
        busA.Sensor = 2'b00;
        runAllRed(0, 5, 8'b01, 90, 0, "t2_a0");
        runGreen(0, 8'b01, 90, "t2_g0");
        runAllRed(0, 5, 8'b10, 30, 1, "t2_a1");
        for (int k = 1; k <= 24; k++) applyStimulus(1, 1'b1);
        checkOutput("t2_before_flash", lamp(0), {8'b10, 8'h06});
        applyStimulus(1, 1'b1);
        checkOutput("t2_flash_entry_lamp",  lamp(0), 16'h0000);
        checkOutput("t2_flash_entry_flash", 16'(busA.Flash), 16'd0);
        checkOutput("t2_flash_phase",       phaseOf(0), 16'd1);
        expFlash = 1'b0;
        for (int k = 0; k < 13; k++) begin
            // 3 quiet, 4 active, 1 quiet (clears wake), 5 active (wakes on last)
            busA.Sensor = ((k >= 3 && k < 7) || k >= 8) ? 2'b01 : 2'b00;
            applyStimulus(1, 1'b1);
            expFlash = ~expFlash;
            if (k < 12) checkOutput("t2_flash_toggle", 16'(busA.Flash), 16'(expFlash));
        end
        checkOutput("t2_wake_flash", 16'(busA.Flash), 16'd0);
        checkOutput("t2_wake_phase", phaseOf(0), 16'd0);
        checkOutput("t2_wake_lamp",  lamp(0), 16'h0000);
        runAllRed(0, 5, 8'b01, 90, 0, "t2_a2");

        // T3: police on approach 1 mid-green of approach 0, then release
        pulseReset();
        busA.Sensor = 2'b11;
        runAllRed(0, 5, 8'b01, 90, 0, "t3_a0");
        for (int k = 1; k <= 10; k++) applyStimulus(1, 1'b1);
        checkOutput("t3_mid_green", lamp(0), {8'b01, 8'h80});
        busA.Police_req = 2'b10;
        applyStimulus(1, 1'b0);
        busA.Police_req = 2'b00;
        checkOutput("t3_police_lamp",  lamp(0), {8'b10, 8'h00});
        checkOutput("t3_police_phase", phaseOf(0), 16'd1);
        applyStimulus(3, 1'b1);
        checkOutput("t3_police_hold", lamp(0), {8'b10, 8'h00});
        busA.Police_req = 2'b01;
        applyStimulus(1, 1'b0);
        busA.Police_req = 2'b00;
        checkOutput("t3_police_req_ignored", lamp(0), {8'b10, 8'h00});
        busA.Police_rel = 1'b1;
        applyStimulus(1, 1'b0);
        busA.Police_rel = 1'b0;
        checkOutput("t3_release_lamp",  lamp(0), 16'h0000);
        checkOutput("t3_release_phase", phaseOf(0), 16'd0);
        runAllRed(0, 5, 8'b01, 90, 0, "t3_a1");

        // T4: police from FLASH, request and release together stay in POLICE
        pulseReset();
        busA.Sensor = 2'b00;
        for (int k = 1; k <= 125; k++) applyStimulus(1, 1'b1);
        applyStimulus(1, 1'b1);
        checkOutput("t4_flash_on", 16'(busA.Flash), 16'd1);
        busA.Police_req = 2'b11;
        applyStimulus(1, 1'b0);
        checkOutput("t4_police_lamp",  lamp(0), {8'b01, 8'h00});
        checkOutput("t4_police_flash", 16'(busA.Flash), 16'd0);
        busA.Police_rel = 1'b1;
        applyStimulus(1, 1'b0);
        checkOutput("t4_req_and_rel", lamp(0), {8'b01, 8'h00});
        busA.Police_req = 2'b00;
        busA.Police_rel = 1'b0;
        applyStimulus(2, 1'b1);
        checkOutput("t4_police_ticks_lamp",  lamp(0), {8'b01, 8'h00});
        checkOutput("t4_police_ticks_flash", 16'(busA.Flash), 16'd0);
        busA.Police_rel = 1'b1;
        applyStimulus(1, 1'b0);
        busA.Police_rel = 1'b0;
        checkOutput("t4_release_lamp",  lamp(0), 16'h0000);
        checkOutput("t4_release_phase", phaseOf(0), 16'd1);
        runAllRed(0, 5, 8'b10, 30, 1, "t4_a1");

        // T5: four approaches in order, 3 -> 0 wrap
        pulseReset();
        runAllRed(1, 5, 8'b0001, 40, 0, "t5_a0");
        runGreen(1, 8'b0001, 40, "t5_g0");
        runAllRed(1, 5, 8'b0010, 30, 1, "t5_a1");
        runGreen(1, 8'b0010, 30, "t5_g1");
        runAllRed(1, 5, 8'b0100, 20, 2, "t5_a2");
        runGreen(1, 8'b0100, 20, "t5_g2");
        runAllRed(1, 5, 8'b1000, 10, 3, "t5_a3");
        runGreen(1, 8'b1000, 10, "t5_g3");
        runAllRed(1, 5, 8'b0001, 40, 0, "t5_wrap");

        // T6: reset mid-green, in FLASH and in POLICE; Tick held low
        pulseReset();
        busA.Sensor = 2'b11;
        runAllRed(0, 5, 8'b01, 90, 0, "t6_a0");
        for (int k = 1; k <= 20; k++) applyStimulus(1, 1'b1);
        checkOutput("t6_mid_green", lamp(0), {8'b01, 8'h70});
        pulseReset();
        checkOutput("t6_rst_green_lamp",  lamp(0), 16'h0000);
        checkOutput("t6_rst_green_phase", phaseOf(0), 16'd0);
        busA.Sensor = 2'b00;
        for (int k = 1; k <= 126; k++) applyStimulus(1, 1'b1);
        checkOutput("t6_flash_on",    16'(busA.Flash), 16'd1);
        checkOutput("t6_flash_phase", phaseOf(0), 16'd1);
        pulseReset();
        checkOutput("t6_rst_flash_flash", 16'(busA.Flash), 16'd0);
        checkOutput("t6_rst_flash_lamp",  lamp(0), 16'h0000);
        checkOutput("t6_rst_flash_phase", phaseOf(0), 16'd0);
        busA.Police_req = 2'b10;
        applyStimulus(1, 1'b0);
        busA.Police_req = 2'b00;
        checkOutput("t6_police_lamp", lamp(0), {8'b10, 8'h00});
        pulseReset();
        checkOutput("t6_rst_police_lamp",  lamp(0), 16'h0000);
        checkOutput("t6_rst_police_phase", phaseOf(0), 16'd0);
        busA.Sensor = 2'b11;
        runAllRed(0, 5, 8'b01, 90, 0, "t6_a1");
        applyStimulus(3, 1'b1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(100, 1'b0);
            checkOutput("t6_hold_lamp",  lamp(0), {8'b01, 8'h87});
            checkOutput("t6_hold_flash", 16'(busA.Flash), 16'd0);
        end
        checkOutput("t6_hold_phase", phaseOf(0), 16'd0);
        applyStimulus(1, 1'b1);
        checkOutput("t6_resume", lamp(0), {8'b01, 8'h86});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
